// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   - rx_state_t     : receiver FSM states (IDLE, START, DATA, STOP)
//   - OVERSAMPLE_DEF : default sample_tick strobes per bit
//   - DATA_BITS_DEF  : default data bits per frame
//   - START_BIT / STOP_BIT : line levels of the frame delimiters
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial-in / byte-out bundle of the UART receiver.
//   sample_tick : oversampling strobe (OVERSAMPLE x baud), driven by master
//   rx          : asynchronous serial line, idle high, driven by master
//   data_out    : last correctly framed byte, driven by slave
//   valid       : one-cycle pulse when data_out updates, driven by slave
//   frame_err   : one-cycle pulse on a low stop bit, driven by slave
//   busy        : frame in progress, driven by slave
// Modports: master = line/tick source and byte consumer, slave = receiver.
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF
);
    logic                 sample_tick;
    logic                 rx;
    logic [DATA_BITS-1:0] data_out;
    logic                 valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output sample_tick, rx,
        input  data_out, valid, frame_err, busy
    );

    modport slave (
        input  sample_tick, rx,
        output data_out, valid, frame_err, busy
    );
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for an asynchronous, idle-high input.
// Both flops preset to 1 on reset so a released reset never looks like a
// falling edge on the line.
//   clk : destination clock
//   rst : asynchronous active-high reset (presets the output to 1)
//   d   : asynchronous input
//   q   : synchronized output, two clk of latency
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, 1 start / DATA_BITS data (LSB first) /
// 1 stop, no parity, idle-high line.
//   clk : system clock, all logic on posedge
//   rst : asynchronous active-high reset
//   bus : uart_rx_if.slave (sample_tick, rx in; data_out, valid, frame_err,
//         busy out, all outputs registered)
// Optional build macro UART_RX_MAJORITY_EN: every bit decision takes the
// 2-of-3 majority of the synchronized line over the decision tick and the two
// ticks before it; otherwise only the decision tick's sample is used.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.slave  bus
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] HALF_DEC = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_DEC = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    rx_state_t            state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] data_r;
    logic                 valid_r;
    logic                 err_r;
    logic                 busy_r;
    logic                 armed;
    logic                 rx_s;
    logic                 bit_val;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.rx),
        .q   (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Line samples from the two ticks preceding the current one. Ticks outside
    // a frame shift in too, so the history is always consecutive ticks.
    logic [1:0] hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= 2'b11;
        end else if (bus.sample_tick) begin
            hist <= {hist[0], rx_s};
        end
    end

    assign bit_val = maj3(hist[1], hist[0], rx_s);
`else
    assign bit_val = rx_s;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            data_r  <= '0;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
            armed   <= 1'b1;
        end else begin
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            if (bus.sample_tick) begin
                // Any high sample re-arms; a framing error below overrides it.
                if (rx_s) armed <= 1'b1;
                case (state)
                    IDLE: begin
                        if (!rx_s && armed) begin
                            state  <= START;
                            cnt    <= '0;
                            busy_r <= 1'b1;
                        end
                    end
                    START: begin
                        if (cnt == HALF_DEC) begin
                            cnt <= '0;
                            if (bit_val == START_BIT) begin
                                state   <= DATA;
                                bit_idx <= '0;
                            end else begin
                                state  <= IDLE;
                                busy_r <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (cnt == FULL_DEC) begin
                            cnt   <= '0;
                            shift <= {bit_val, shift[DATA_BITS-1:1]};
                            if (bit_idx == LAST_IDX) begin
                                state   <= STOP;
                                bit_idx <= '0;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (cnt == FULL_DEC) begin
                            cnt    <= '0;
                            state  <= IDLE;
                            busy_r <= 1'b0;
                            if (bit_val == STOP_BIT) begin
                                data_r  <= shift;
                                valid_r <= 1'b1;
                            end else begin
                                err_r <= 1'b1;
                                armed <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        cnt    <= '0;
                        busy_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.data_out  = data_r;
    assign bus.valid     = valid_r;
    assign bus.frame_err = err_r;
    assign bus.busy      = busy_r;
endmodule
